// File: rtl/bp_fe_icache_tb_pkg.sv
// Shared types for the icache trace driver and its checker.
//   - bp_fe_trace_state_e : driver FSM states
//   - DECLARE_BP_FE_TRACE_ENTRY_S : declares a {last, vaddr, instr} trace entry
//     struct at the caller's widths
//   - BP_FE_TRACE_ENTRY_WIDTH : bit width of one packed trace ROM word
`ifndef BP_FE_ICACHE_TB_PKG_SV
`define BP_FE_ICACHE_TB_PKG_SV

`define BP_FE_TRACE_ENTRY_WIDTH(vaddr_w, instr_w) (1 + (vaddr_w) + (instr_w))

`define DECLARE_BP_FE_TRACE_ENTRY_S(name, vaddr_w, instr_w) \
  typedef struct packed {                                   \
    logic                  last;                            \
    logic [(vaddr_w)-1:0]  vaddr;                           \
    logic [(instr_w)-1:0]  instr;                           \
  } name

package bp_fe_icache_tb_pkg;

  localparam int unsigned vaddr_width_gp = 39;
  localparam int unsigned instr_width_gp = 32;

  // Trace entry at the default widths
  `DECLARE_BP_FE_TRACE_ENTRY_S(bp_fe_trace_entry_s, vaddr_width_gp, instr_width_gp);

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_issue = 2'd1,
    e_wait  = 2'd2,
    e_done  = 2'd3
  } bp_fe_trace_state_e;

endpackage

`endif

// File: rtl/bp_fe_icache_trace_checker.sv
// Expected-value register, comparator and saturating mismatch counter.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_capture       : load i_exp_instr into the expected-value register
//   i_exp_instr     : expected instruction of the request being accepted
//   i_data_v        : a response to compare against the held expectation
//   i_data          : returned instruction
//   i_spurious      : a response arrived with nothing outstanding
//   o_err_count     : mismatch + spurious count, saturates at all-ones
module bp_fe_icache_trace_checker
  import bp_fe_icache_tb_pkg::*;
#(
  parameter int instr_width_p = 32,
  parameter int err_width_p   = 16
)
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_capture,
  input  logic [instr_width_p-1:0] i_exp_instr,
  input  logic                     i_data_v,
  input  logic [instr_width_p-1:0] i_data,
  input  logic                     i_spurious,
  output logic [err_width_p-1:0]   o_err_count
);

  logic [instr_width_p-1:0] r_exp_instr;
  logic [err_width_p-1:0]   r_err_count;
  logic                     w_mismatch;
  logic                     w_bump;
  logic                     w_saturated;

  assign w_mismatch  = i_data_v & (i_data != r_exp_instr);
  assign w_bump      = w_mismatch | i_spurious;
  assign w_saturated = &r_err_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exp_instr <= '0;
      r_err_count <= '0;
    end else begin
      if (i_capture) begin
        r_exp_instr <= i_exp_instr;
      end
      if (w_bump && !w_saturated) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign o_err_count = r_err_count;

endmodule

// File: rtl/bp_fe_icache_trace_driver.sv
// Replays a trace ROM of fetch requests into the icache request port, one
// request outstanding at a time, and checks each returned instruction.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   rom_addr_o      : current trace ROM index
//   rom_data_i      : combinational ROM word {last, vaddr, expected_instr}
//   fetch_v_o       : fetch request valid (held until accepted)
//   fetch_vaddr_o   : fetch address of the current ROM entry
//   fetch_ready_i   : icache accepts when high together with fetch_v_o
//   data_v_i/data_i : instruction response
//   done_o          : trace finished (normally or by timeout)
//   pass_o          : with done_o, no mismatches and no timeout
//   timeout_o       : sticky, a response took too long
//   err_count_o     : saturating mismatch count
module bp_fe_icache_trace_driver
  import bp_fe_icache_tb_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int instr_width_p    = 32,
  parameter int trace_els_p      = 64,
  parameter int timeout_cycles_p = 1024,
  parameter int err_width_p      = 16
)
(
  input  logic                                                      clk_i,
  input  logic                                                      reset_i,
  output logic [$clog2(trace_els_p)-1:0]                            rom_addr_o,
  input  logic [`BP_FE_TRACE_ENTRY_WIDTH(vaddr_width_p, instr_width_p)-1:0] rom_data_i,
  output logic                                                      fetch_v_o,
  output logic [vaddr_width_p-1:0]                                  fetch_vaddr_o,
  input  logic                                                      fetch_ready_i,
  input  logic                                                      data_v_i,
  input  logic [instr_width_p-1:0]                                  data_i,
  output logic                                                      done_o,
  output logic                                                      pass_o,
  output logic                                                      timeout_o,
  output logic [err_width_p-1:0]                                    err_count_o
);

  localparam int unsigned lg_els_lp      = $clog2(trace_els_p);
  localparam int unsigned timer_width_lp = $clog2(timeout_cycles_p) + 1;
  localparam logic [timer_width_lp-1:0] timer_max_lp =
    timer_width_lp'(timeout_cycles_p - 1);

  `DECLARE_BP_FE_TRACE_ENTRY_S(trace_entry_s, vaddr_width_p, instr_width_p);

  trace_entry_s             w_entry;
  bp_fe_trace_state_e       r_state, w_state_n;
  logic [lg_els_lp-1:0]     r_index, w_index_n;
  logic [timer_width_lp-1:0] r_timer, w_timer_n;
  logic                     r_last;
  logic                     r_timeout, w_timeout_n;
  logic                     w_capture;
  logic                     w_check;
  logic                     w_spurious;

  assign w_entry       = trace_entry_s'(rom_data_i);
  assign rom_addr_o    = r_index;
  assign fetch_vaddr_o = w_entry.vaddr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= e_reset;
      r_index   <= '0;
      r_timer   <= '0;
      r_last    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_index   <= w_index_n;
      r_timer   <= w_timer_n;
      r_timeout <= w_timeout_n;
      if (w_capture) begin
        r_last <= w_entry.last;
      end
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_index_n   = r_index;
    w_timer_n   = '0;
    w_timeout_n = r_timeout;
    w_capture   = 1'b0;
    w_check     = 1'b0;
    w_spurious  = 1'b0;
    fetch_v_o   = 1'b0;
    done_o      = 1'b0;

    unique case (r_state)
      e_reset: begin
        // A straggling response from before reset lands here and is dropped
        w_state_n = e_issue;
      end
      e_issue: begin
        fetch_v_o  = 1'b1;
        w_spurious = data_v_i;
        if (fetch_ready_i) begin
          w_capture = 1'b1;
          w_state_n = e_wait;
        end
      end
      e_wait: begin
        w_timer_n = r_timer + 1'b1;
        // A response in the final timer cycle still counts as on time
        if (data_v_i) begin
          w_check = 1'b1;
          if (r_last || (r_index == '1)) begin
            w_state_n = e_done;
          end else begin
            w_index_n = r_index + 1'b1;
            w_state_n = e_issue;
          end
        end else if (r_timer == timer_max_lp) begin
          w_timeout_n = 1'b1;
          w_state_n   = e_done;
        end
      end
      e_done: begin
        done_o = 1'b1;
      end
      default: begin
        w_state_n = e_reset;
      end
    endcase

    // Status outputs stay quiet for the whole reset interval
    if (reset_i) begin
      fetch_v_o = 1'b0;
      done_o    = 1'b0;
    end
  end

  bp_fe_icache_trace_checker #(
    .instr_width_p(instr_width_p),
    .err_width_p  (err_width_p)
  ) u_checker (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_capture  (w_capture),
    .i_exp_instr(w_entry.instr),
    .i_data_v   (w_check),
    .i_data     (data_i),
    .i_spurious (w_spurious),
    .o_err_count(err_count_o)
  );

  assign timeout_o = r_timeout;
  assign pass_o    = done_o & (err_count_o == '0) & ~r_timeout;

endmodule

// File: tb/tb_bp_fe_icache_trace_driver.sv
// Bench for bp_fe_icache_trace_driver: a reactive icache model answers each
// fetch according to a per-entry policy, and a trace-level reference model
// predicts run length, accepted addresses, error count and final status.
module tb_bp_fe_icache_trace_driver;

  localparam int VW  = 39;
  localparam int IW  = 32;
  localparam int ELS = 8;
  localparam int TO  = 8;
  localparam int EW  = 16;

  logic          clk;
  logic          reset_i;
  logic [2:0]    rom_addr_o;
  logic [1+VW+IW-1:0] rom_data;
  logic          fetch_v_o;
  logic [VW-1:0] fetch_vaddr_o;
  logic          fetch_ready_i;
  logic          data_v_i;
  logic [IW-1:0] data_i;
  logic          done_o;
  logic          pass_o;
  logic          timeout_o;
  logic [EW-1:0] err_count_o;

  // Trace ROM contents and per-entry response policy
  logic [VW-1:0] t_vaddr [ELS];
  logic [IW-1:0] t_instr [ELS];
  logic          t_last  [ELS];
  int            p_rdy   [ELS];
  int            p_d     [ELS];
  bit            p_bad   [ELS];
  logic [IW-1:0] p_badval[ELS];
  bit            p_spur  [ELS];
  int            rst_k;

  int n_cmp = 0;
  int n_mis = 0;

  assign rom_data = {t_last[rom_addr_o], t_vaddr[rom_addr_o], t_instr[rom_addr_o]};

  bp_fe_icache_trace_driver #(
    .vaddr_width_p   (VW),
    .instr_width_p   (IW),
    .trace_els_p     (ELS),
    .timeout_cycles_p(TO),
    .err_width_p     (EW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data),
    .fetch_v_o    (fetch_v_o),
    .fetch_vaddr_o(fetch_vaddr_o),
    .fetch_ready_i(fetch_ready_i),
    .data_v_i     (data_v_i),
    .data_i       (data_i),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .timeout_o    (timeout_o),
    .err_count_o  (err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trace-level reference: walk entries, stop on last/final entry/timeout
  int exp_cyc, exp_n, exp_err;
  bit exp_to, exp_pass;

  task automatic model_trace();
    exp_cyc = 1; exp_n = 0; exp_err = 0; exp_to = 0;
    for (int k = 0; k < ELS; k++) begin
      exp_n++;
      if (p_spur[k]) exp_err++;
      exp_cyc += p_rdy[k] + 1;
      if (p_d[k] > TO) begin
        exp_to = 1;
        exp_cyc += TO;
        break;
      end
      exp_cyc += p_d[k];
      if (p_bad[k]) exp_err++;
      if (t_last[k] || k == ELS - 1) break;
    end
    if (exp_err > 65535) exp_err = 65535;
    exp_pass = (exp_err == 0) && !exp_to;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; data_v_i = 1'b0; fetch_ready_i = 1'b0; data_i = $urandom;
    repeat (2) @(negedge clk);
    check_eq("rst_fetch_v", 64'(fetch_v_o), 64'(0));
    check_eq("rst_done", 64'(done_o), 64'(0));
    check_eq("rst_pass", 64'(pass_o), 64'(0));
    check_eq("rst_err", 64'(err_count_o), 64'(0));
    check_eq("rst_timeout", 64'(timeout_o), 64'(0));
    reset_i = 1'b0;
  endtask

  task automatic run_scenario(input string name);
    int  cyc, n_acc, k, hold, cnt;
    bit  pending, spur_done, did_rst, finished;
    model_trace();
    do_reset();
    cyc = 0; n_acc = 0; k = 0; hold = 0; cnt = 0;
    pending = 0; spur_done = 0; did_rst = 0; finished = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      cyc++;
      data_v_i = 1'b0;
      data_i = $urandom;
      fetch_ready_i = 1'($urandom_range(0, 1));
      if (done_o) begin
        finished = 1;
        break;
      end
      if (pending) begin
        cnt++;
        if (k == rst_k && !did_rst) begin
          // Pulse reset mid-wait with a wrong response landing on the same edge
          reset_i = 1'b1;
          data_v_i = 1'b1;
          data_i = t_instr[k] ^ 32'h1;
          @(negedge clk);
          check_eq({name, "_midrst_fetch_v"}, 64'(fetch_v_o), 64'(0));
          check_eq({name, "_midrst_err"}, 64'(err_count_o), 64'(0));
          check_eq({name, "_midrst_done"}, 64'(done_o), 64'(0));
          reset_i = 1'b0; data_v_i = 1'b0;
          k = 0; hold = 0; cnt = 0; n_acc = 0; cyc = 0;
          pending = 0; spur_done = 0; did_rst = 1;
        end else if (cnt == p_d[k]) begin
          data_v_i = 1'b1;
          data_i = p_bad[k] ? p_badval[k] : t_instr[k];
          pending = 0; k++; hold = 0; spur_done = 0;
        end
      end else if (fetch_v_o) begin
        if (k >= ELS) begin
          check_eq({name, "_extra_fetch"}, 64'(1), 64'(0));
          break;
        end
        check_eq({name, "_vaddr"}, 64'(fetch_vaddr_o), 64'(t_vaddr[k]));
        if (p_spur[k] && !spur_done) begin
          data_v_i = 1'b1;
          spur_done = 1;
        end
        if (hold < p_rdy[k]) begin
          fetch_ready_i = 1'b0;
          hold++;
        end else begin
          fetch_ready_i = 1'b1;
          pending = 1; cnt = 0; n_acc++;
        end
      end
    end
    if (!finished) check_eq({name, "_done_budget"}, 64'(0), 64'(1));
    check_eq({name, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_eq({name, "_accepts"}, 64'(n_acc), 64'(exp_n));
    check_eq({name, "_pass"}, 64'(pass_o), 64'(exp_pass));
    check_eq({name, "_err"}, 64'(err_count_o), 64'(exp_err));
    check_eq({name, "_timeout"}, 64'(timeout_o), 64'(exp_to));
    // Done is absorbing: stray responses and ready are ignored
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_v_i = 1'($urandom_range(0, 1));
      data_i = $urandom;
      fetch_ready_i = 1'($urandom_range(0, 1));
      check_eq({name, "_post_fetch_v"}, 64'(fetch_v_o), 64'(0));
      check_eq({name, "_post_done"}, 64'(done_o), 64'(1));
      check_eq({name, "_post_err"}, 64'(err_count_o), 64'(exp_err));
    end
    data_v_i = 1'b0;
  endtask

  task automatic load_base();
    for (int k = 0; k < ELS; k++) begin
      t_vaddr[k]  = VW'(64'h8000_0000 + 64'(4 * k));
      t_instr[k]  = 32'h13 + 32'(32'h80 * k);
      t_last[k]   = (k == 2);
      p_rdy[k]    = 0;
      p_d[k]      = 1;
      p_bad[k]    = 0;
      p_badval[k] = '0;
      p_spur[k]   = 0;
    end
    rst_k = -1;
  endtask

  task automatic load_random();
    logic [63:0] r;
    for (int k = 0; k < ELS; k++) begin
      r = {$urandom, $urandom};
      t_vaddr[k] = r[VW-1:0];
      t_instr[k] = $urandom;
      t_last[k]  = ($urandom_range(0, 99) < 15);
      p_rdy[k]   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      case ($urandom_range(0, 9))
        0:       p_d[k] = $urandom_range(TO + 1, TO + 4);
        1:       p_d[k] = TO;
        default: p_d[k] = $urandom_range(1, 6);
      endcase
      p_bad[k]    = ($urandom_range(0, 4) == 0);
      p_badval[k] = t_instr[k] ^ ($urandom | 32'h1);
      p_spur[k]   = ($urandom_range(0, 9) == 0);
    end
    rst_k = -1;
  endtask

  initial begin
    reset_i = 1'b1; fetch_ready_i = 1'b0; data_v_i = 1'b0; data_i = '0;
    load_base();

    load_base();
    run_scenario("hit3");

    load_base();
    p_bad[1] = 1; p_badval[1] = 32'hDEAD;
    run_scenario("bad1");

    load_base();
    p_rdy[0] = 5;
    run_scenario("stall5");

    load_base();
    p_d[0] = 100;
    run_scenario("timeout");

    load_base();
    p_d[0] = TO;
    run_scenario("edge_resp");

    load_base();
    rst_k = 1;
    run_scenario("midrst");

    load_base();
    for (int k = 0; k < ELS; k++) t_last[k] = 1'b0;
    run_scenario("nowrap");

    load_base();
    p_spur[1] = 1;
    run_scenario("spurious");

    for (int s = 0; s < 30; s++) begin
      load_random();
      run_scenario($sformatf("rand%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
